// File: rtl/jtag_deserializer_if.sv
// Handshake/data bundle between a JTAG bit source, the deserializer and its word consumer.
// The master side drives serial bits and acknowledgements; the slave side is the deserializer.
`timescale 1ns / 1ps

interface jtag_deserializer_if #(
  parameter int unsigned LENGTH = 32
);
  logic              start;
  logic              shiftEn;
  logic              jtagInput;
  logic              dataReady;
  logic              clrOverrun;
  logic [LENGTH-1:0] dataOut;
  logic              dataValid;
  logic              busy;
  logic              overrun;

  modport master (
    output start,
    output shiftEn,
    output jtagInput,
    output dataReady,
    output clrOverrun,
    input  dataOut,
    input  dataValid,
    input  busy,
    input  overrun
  );

  modport slave (
    input  start,
    input  shiftEn,
    input  jtagInput,
    input  dataReady,
    input  clrOverrun,
    output dataOut,
    output dataValid,
    output busy,
    output overrun
  );
endinterface

// File: rtl/jtag_deserializer.sv
// Serial-to-parallel JTAG word assembler: LSB-first bits are shifted in under shiftEn and the
// completed word is parked in a one-entry output buffer with a valid/ready handshake.
`timescale 1ns / 1ps

module jtag_deserializer #(
  parameter int unsigned LENGTH = 32
) (
  input logic                clk,
  input logic                rst,
  jtag_deserializer_if.slave bus
);

  localparam int unsigned CntW = (LENGTH > 2) ? $clog2(LENGTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(LENGTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [LENGTH-1:0]   shift_q, shift_d;
  logic [LENGTH-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;

  logic                complete;
  logic                overrun_set;
  logic [LENGTH-1:0]   shift_word;

  assign shift_word = {bus.jtagInput, shift_q[LENGTH-1:1]};

  // Frame sequencing: start always (re)arms a zero bit count and masks shiftEn that cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StShift;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (bus.start) begin
          cnt_d = '0;
        end else if (bus.shiftEn) begin
          shift_d = shift_word;
          if (cnt_q == CntMax) begin
            complete = 1'b1;
            state_d  = StIdle;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output buffer runs its handshake regardless of the frame state. A word completing while the
  // buffer is full and not being drained is dropped and flagged.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_set = 1'b0;
    if (complete) begin
      if (!valid_q || bus.dataReady) begin
        data_d  = shift_word;
        valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (valid_q && bus.dataReady) begin
      valid_d = 1'b0;
    end
    overrun_d = overrun_set | (overrun_q & ~bus.clrOverrun);
    busy_d    = (state_d == StShift);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.dataOut   = data_q;
  assign bus.dataValid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

`ifndef SYNTHESIS
  // A pending word must not change under the consumer until it is accepted.
  property p_hold_pending;
    @(posedge clk) disable iff (!rst)
      (valid_q && !bus.dataReady) |=> (valid_q && $stable(data_q));
  endproperty
  a_hold_pending: assert property (p_hold_pending);

  property p_busy_tracks_state;
    @(posedge clk) disable iff (!rst) busy_q == (state_q == StShift);
  endproperty
  a_busy_tracks_state: assert property (p_busy_tracks_state);
`endif

endmodule

// File: tb/tb_jtag_deserializer.sv
// Directed bench for jtag_deserializer: stimulus queues expected accepted words, a monitor
// checks each word at the moment the consumer takes it; flags are checked inline.
`timescale 1ns / 1ps

module tb_jtag_deserializer;

  localparam int unsigned LENGTH = 32;

  logic clk;
  logic rst;

  jtag_deserializer_if #(.LENGTH(LENGTH)) bus ();

  jtag_deserializer #(.LENGTH(LENGTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  // Monitor: a word is consumed on any edge where valid and ready are both high.
  always @(negedge clk) begin
    if (rst && bus.dataValid === 1'b1 && bus.dataReady === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL accept_unexpected: got 0x%0h, expected no word (t=%0t)",
                 bus.dataOut, $time);
      end else begin
        check("accept_word", {32'd0, bus.dataOut}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.shiftEn   = 1'b1;
    bus.jtagInput = b;
    tick();
    bus.shiftEn   = 1'b0;
    bus.jtagInput = 1'b0;
  endtask

  // Full frame; ready_last/clr_last are asserted only alongside the final bit.
  task automatic send_word(input logic [31:0] w, input logic ready_last, input logic clr_last);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin
        bus.dataReady  = ready_last;
        bus.clrOverrun = clr_last;
      end
      send_bit(w[i]);
    end
    bus.dataReady  = 1'b0;
    bus.clrOverrun = 1'b0;
  endtask

  task automatic consume();
    bus.dataReady = 1'b1;
    tick();
    bus.dataReady = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    bus.start      = 1'b0;
    bus.shiftEn    = 1'b0;
    bus.jtagInput  = 1'b0;
    bus.dataReady  = 1'b0;
    bus.clrOverrun = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("reset_dataOut", {32'd0, bus.dataOut}, 64'd0);
    check("reset_flags", {61'd0, bus.dataValid, bus.busy, bus.overrun}, 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Basic frame
    exp_q.push_back(32'hA5A5_0F0F);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("basic_busy_after_start", {63'd0, bus.busy}, 64'd1);
    w = 32'hA5A5_0F0F;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) check("basic_valid_before_last", {63'd0, bus.dataValid}, 64'd0);
      send_bit(w[i]);
    end
    check("basic_dataOut", {32'd0, bus.dataOut}, {32'd0, 32'hA5A5_0F0F});
    check("basic_valid_busy", {62'd0, bus.dataValid, bus.busy}, 64'b10);
    tick();
    check("basic_valid_held", {63'd0, bus.dataValid}, 64'd1);
    consume();
    check("basic_valid_cleared", {63'd0, bus.dataValid}, 64'd0);

    // Gapped frame: idle shiftEn for 5 cycles after the 11th bit; start-less idle is ignored
    exp_q.push_back(32'h0000_0001);
    w = 32'h0000_0001;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 11) begin
        bus.jtagInput = 1'b1;
        repeat (5) tick();
        bus.jtagInput = 1'b0;
        check("gap_busy_held", {62'd0, bus.dataValid, bus.busy}, 64'b01);
      end
      if (i == 31) check("gap_valid_before_last", {63'd0, bus.dataValid}, 64'd0);
      send_bit(w[i]);
    end
    check("gap_dataOut", {32'd0, bus.dataOut}, 64'd1);
    check("gap_valid", {63'd0, bus.dataValid}, 64'd1);
    consume();

    // Overrun: second word dropped; clear coinciding with the set loses
    exp_q.push_back(32'h1111_1111);
    send_word(32'h1111_1111, 1'b0, 1'b0);
    check("ovr_first_no_flag", {63'd0, bus.overrun}, 64'd0);
    send_word(32'h2222_2222, 1'b0, 1'b1);
    check("ovr_dataOut_kept", {32'd0, bus.dataOut}, {32'd0, 32'h1111_1111});
    check("ovr_flag_set_wins", {62'd0, bus.overrun, bus.dataValid}, 64'b11);
    tick();
    check("ovr_sticky", {63'd0, bus.overrun}, 64'd1);
    bus.clrOverrun = 1'b1;
    tick();
    bus.clrOverrun = 1'b0;
    check("ovr_cleared", {63'd0, bus.overrun}, 64'd0);
    consume();

    // Completion coinciding with acceptance of the pending word
    exp_q.push_back(32'h2222_2222);
    send_word(32'h2222_2222, 1'b0, 1'b0);
    exp_q.push_back(32'h3333_3333);
    send_word(32'h3333_3333, 1'b1, 1'b0);
    check("simul_dataOut", {32'd0, bus.dataOut}, {32'd0, 32'h3333_3333});
    check("simul_valid_ovr", {62'd0, bus.dataValid, bus.overrun}, 64'b10);
    consume();

    // Abort after 12 bits, then a full frame
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    exp_q.push_back(32'hDEAD_BEEF);
    w = 32'hDEAD_BEEF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) check("abort_valid_before_last", {63'd0, bus.dataValid}, 64'd0);
      send_bit(w[i]);
    end
    check("abort_dataOut", {32'd0, bus.dataOut}, {32'd0, 32'hDEAD_BEEF});
    check("abort_valid_ovr", {62'd0, bus.dataValid, bus.overrun}, 64'b10);
    consume();

    // Mid-frame asynchronous reset with a word pending; bits without start are ignored after
    send_word(32'h1234_5678, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) send_bit(1'b1);
    check("pre_reset_state", {62'd0, bus.dataValid, bus.busy}, 64'b11);
    #2 rst = 1'b0;
    #1;
    check("midrst_dataOut", {32'd0, bus.dataOut}, 64'd0);
    check("midrst_flags", {61'd0, bus.dataValid, bus.busy, bus.overrun}, 64'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) send_bit(1'b1);
    check("post_rst_no_word", {62'd0, bus.dataValid, bus.busy}, 64'd0);
    check("post_rst_dataOut", {32'd0, bus.dataOut}, 64'd0);

    tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
